// File: rtl/data_bus_master.sv
// data_bus_master: initiator side of the CPU data bus; one load/store/fetch at a time,
// with read-data extension, misalignment detection and responder timeout.
`ifndef MEM_LEN
`define MEM_LEN 1:0
`define MEM_LEN_B 2'd0
`define MEM_LEN_H 2'd1
`define MEM_LEN_W 2'd2
`endif
`ifndef MEM_ACCESS
`define MEM_ACCESS 1:0
`define MEM_ACCESS_NONE 2'd0
`define MEM_ACCESS_R 2'd1
`define MEM_ACCESS_W 2'd2
`define MEM_ACCESS_X 2'd3
`endif

module data_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                res,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_exec,
  input  logic [`MEM_LEN]     req_len,
  input  logic                req_signed,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic [31:0]         db_addr,
  output logic [31:0]         db_dataOut,
  output logic [`MEM_ACCESS]  db_accessType,
  output logic [`MEM_LEN]     db_memLen,
  input  logic [31:0]         db_dataIn,
  input  logic                db_ready
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;
  state_t state, state_n;
  logic rsp_valid_n, sgn, sgn_n, mis, timeout;
  logic [31:0] rsp_rdata_n, addr_n, dout_n, cnt, cnt_n, ext;
  logic [1:0] rsp_err_n;
  logic [`MEM_ACCESS] type_n;
  logic [`MEM_LEN] len_n;
  assign req_ready = state == IDLE;
  assign mis = (req_len == `MEM_LEN_H && req_addr[0]) || (req_len == `MEM_LEN_W && req_addr[1:0] != 2'b00);
  assign timeout = TIMEOUT_CYCLES != 0 && cnt == 32'(TIMEOUT_CYCLES - 1);
  // db_memLen doubles as the latched request length for extension
  assign ext = db_memLen == `MEM_LEN_B ? {{24{sgn & db_dataIn[7]}}, db_dataIn[7:0]} :
               db_memLen == `MEM_LEN_H ? {{16{sgn & db_dataIn[15]}}, db_dataIn[15:0]} : db_dataIn;
  always_comb begin
    state_n = state;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n = rsp_err;
    addr_n = db_addr;
    dout_n = db_dataOut;
    type_n = db_accessType;
    len_n = db_memLen;
    sgn_n = sgn;
    cnt_n = cnt;
    case (state)
      IDLE: if (req_valid) begin
        if (mis) begin
          rsp_valid_n = 1'b1;
          rsp_err_n = 2'b01;
          rsp_rdata_n = '0;
        end else begin
          addr_n = req_addr;
          dout_n = req_wdata;
          len_n = req_len;
          sgn_n = req_signed;
          type_n = req_write ? `MEM_ACCESS_W : req_exec ? `MEM_ACCESS_X : `MEM_ACCESS_R;
          cnt_n = '0;
          state_n = ACCESS;
        end
      end
      ACCESS: if (db_ready) begin
        type_n = `MEM_ACCESS_NONE;
        state_n = db_accessType == `MEM_ACCESS_W ? IDLE : RDATA;
        if (db_accessType == `MEM_ACCESS_W) begin
          rsp_valid_n = 1'b1;
          rsp_err_n = 2'b00;
          rsp_rdata_n = '0;
        end
      end else begin
        cnt_n = cnt + 32'd1;
        if (timeout) begin
          type_n = `MEM_ACCESS_NONE;
          rsp_valid_n = 1'b1;
          rsp_err_n = 2'b10;
          rsp_rdata_n = '0;
          state_n = IDLE;
        end
      end
      RDATA: begin
        rsp_rdata_n = ext;
        rsp_valid_n = 1'b1;
        rsp_err_n = 2'b00;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 2'b00;
      db_addr <= '0;
      db_dataOut <= '0;
      db_accessType <= `MEM_ACCESS_NONE;
      db_memLen <= `MEM_LEN_W;
      sgn <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err <= rsp_err_n;
      db_addr <= addr_n;
      db_dataOut <= dout_n;
      db_accessType <= type_n;
      db_memLen <= len_n;
      sgn <= sgn_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_data_bus_master.sv
// tb_data_bus_master: big-endian memory responder plus reference-model scoreboard
// for directed and random load/store/fetch traffic, timeout and reset abort.
`ifndef MEM_LEN
`define MEM_LEN 1:0
`define MEM_LEN_B 2'd0
`define MEM_LEN_H 2'd1
`define MEM_LEN_W 2'd2
`endif
`ifndef MEM_ACCESS
`define MEM_ACCESS 1:0
`define MEM_ACCESS_NONE 2'd0
`define MEM_ACCESS_R 2'd1
`define MEM_ACCESS_W 2'd2
`define MEM_ACCESS_X 2'd3
`endif

module tb_data_bus_master;
  logic clk = 1'b0, res = 1'b1;
  always #5 clk = ~clk;
  logic req_valid = 0, req_write = 0, req_exec = 0, req_signed = 0, req_ready, rsp_valid, db_ready;
  logic [1:0] req_len = 2'd2, rsp_err, db_accessType, db_memLen;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata, db_addr, db_dataOut, db_dataIn = 0;
  logic t_valid = 0, t_ready, t_rsp_valid, t_db_ready = 0;
  logic [1:0] t_err, t_type, t_len;
  logic [31:0] t_rdata, t_addr, t_dout, t_din = 32'hFFFF_FFFF;
  int n_tests = 0, n_fail = 0, low_cnt = 0;
  bit rand_rdy = 0, rbit = 1;
  logic [7:0] bus_mem [4096];
  logic [7:0] ref_mem [4096];
  logic [31:0] last_addr, last_dout;
  logic [1:0] last_type, last_len;

  data_bus_master dut (.clk(clk), .res(res), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_exec(req_exec), .req_len(req_len), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .db_addr(db_addr), .db_dataOut(db_dataOut), .db_accessType(db_accessType),
    .db_memLen(db_memLen), .db_dataIn(db_dataIn), .db_ready(db_ready));

  data_bus_master #(.TIMEOUT_CYCLES(4)) dut_to (.clk(clk), .res(res), .req_valid(t_valid),
    .req_ready(t_ready), .req_write(1'b0), .req_exec(1'b0), .req_len(`MEM_LEN_W),
    .req_signed(1'b0), .req_addr(32'h100), .req_wdata(32'h0), .rsp_valid(t_rsp_valid),
    .rsp_rdata(t_rdata), .rsp_err(t_err), .db_addr(t_addr), .db_dataOut(t_dout),
    .db_accessType(t_type), .db_memLen(t_len), .db_dataIn(t_din), .db_ready(t_db_ready));

  assign db_ready = (low_cnt == 0) && (!rand_rdy || rbit);

  function automatic int nbytes(input logic [1:0] len);
    return len == `MEM_LEN_B ? 1 : len == `MEM_LEN_H ? 2 : 4;
  endfunction

  // Big-endian responder: lowest address holds the most significant byte.
  always @(posedge clk) begin
    logic [31:0] v;
    int n;
    rbit <= 1'($urandom_range(0, 1));
    db_dataIn <= $urandom;
    if (db_accessType != `MEM_ACCESS_NONE && low_cnt > 0) low_cnt <= low_cnt - 1;
    if (db_accessType != `MEM_ACCESS_NONE && db_ready) begin
      n = nbytes(db_memLen);
      last_addr = db_addr;
      last_dout = db_dataOut;
      last_type = db_accessType;
      last_len = db_memLen;
      if (db_accessType == `MEM_ACCESS_W) begin
        for (int i = 0; i < n; i++) bus_mem[(db_addr[11:0] + 12'(i))] = db_dataOut[8*(n-1-i) +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(bus_mem[(db_addr[11:0] + 12'(i))]);
        db_dataIn <= v;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input bit w, input bit x, input logic [1:0] len, input bit sg,
                      input logic [31:0] addr, input logic [31:0] wdata, input int lat);
    logic [31:0] er, v, a0, d0;
    logic [1:0] ee, et, l0, t0;
    int n, k;
    bit mis, stable, typok, got;
    n = nbytes(len);
    mis = (len == `MEM_LEN_H && addr[0]) || (len == `MEM_LEN_W && addr[1:0] != 0);
    er = 0;
    ee = mis ? 2'b01 : 2'b00;
    et = mis ? `MEM_ACCESS_NONE : w ? `MEM_ACCESS_W : x ? `MEM_ACCESS_X : `MEM_ACCESS_R;
    if (!mis && w) for (int i = 0; i < n; i++) ref_mem[(addr[11:0] + 12'(i))] = wdata[8*(n-1-i) +: 8];
    if (!mis && !w) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v * 256 + 32'(ref_mem[(addr[11:0] + 12'(i))]);
      if (sg && len == `MEM_LEN_B && v >= 128) v = v | 32'hFFFF_FF00;
      if (sg && len == `MEM_LEN_H && v >= 32768) v = v | 32'hFFFF_0000;
      er = v;
    end
    @(negedge clk);
    req_valid = 1; req_write = w; req_exec = x; req_len = len; req_signed = sg;
    req_addr = addr; req_wdata = wdata;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    check("req_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 0;
    got = 0; stable = 1; typok = 1; k = 0;
    a0 = 0; d0 = 0; l0 = 0; t0 = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin a0 = db_addr; d0 = db_dataOut; l0 = db_memLen; t0 = db_accessType; end
      if (mis) typok &= db_accessType == `MEM_ACCESS_NONE;
      else if (db_accessType != `MEM_ACCESS_NONE) begin
        typok &= db_accessType == et;
        stable &= db_addr == a0 && db_dataOut == d0 && db_memLen == l0;
      end
      if (rsp_valid) begin got = 1; k = c; break; end
    end
    check("rsp_seen", 32'(got), 1);
    check("rdata", rsp_rdata, er);
    check("err", 32'(rsp_err), 32'(ee));
    check("ready_at_rsp", 32'(req_ready), 1);
    check("acc_type", 32'(typok), 1);
    if (!mis) begin
      check("bus_addr", a0, addr);
      check("first_type", 32'(t0), 32'(et));
      check("bus_stable", 32'(stable), 1);
    end
    if (lat > 0) check("latency", k, lat);
    @(negedge clk);
    check("pulse", 32'(rsp_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit seen;
    for (int i = 0; i < 4096; i++) begin bus_mem[i] = 0; ref_mem[i] = 0; end
    bus_mem[12'h100] = 8'h80; bus_mem[12'h101] = 8'h01; bus_mem[12'h102] = 8'h7F; bus_mem[12'h103] = 8'hFE;
    ref_mem[12'h100] = 8'h80; ref_mem[12'h101] = 8'h01; ref_mem[12'h102] = 8'h7F; ref_mem[12'h103] = 8'hFE;
    repeat (3) @(posedge clk);
    @(negedge clk) res = 0;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", 32'(rsp_err), 0);
    check("rst_addr", db_addr, 0);
    check("rst_dout", db_dataOut, 0);
    check("rst_type", 32'(db_accessType), 32'(`MEM_ACCESS_NONE));
    check("rst_len", 32'(db_memLen), 32'(`MEM_LEN_W));
    check("rst_ready", 32'(req_ready), 1);

    xfer(0, 0, `MEM_LEN_B, 1, 32'h100, 0, 3);
    check("rd_b_s", rsp_rdata, 32'hFFFF_FF80);
    xfer(0, 0, `MEM_LEN_B, 0, 32'h100, 0, 3);
    check("rd_b_u", rsp_rdata, 32'h0000_0080);
    xfer(0, 0, `MEM_LEN_H, 1, 32'h102, 0, 3);
    check("rd_h_s", rsp_rdata, 32'h0000_7FFE);
    xfer(0, 1, `MEM_LEN_W, 0, 32'h100, 0, 3);
    check("fetch_w", rsp_rdata, 32'h8001_7FFE);
    xfer(1, 0, `MEM_LEN_W, 0, 32'h200, 32'hDEAD_BEEF, 2);
    xfer(0, 0, `MEM_LEN_W, 1, 32'h200, 0, 3);
    check("st_rd_w", rsp_rdata, 32'hDEAD_BEEF);
    xfer(1, 0, `MEM_LEN_B, 0, 32'hA000_0001, 32'h1234_56A5, 2);
    check("st_b_type", 32'(last_type), 32'(`MEM_ACCESS_W));
    check("st_b_len", 32'(last_len), 32'(`MEM_LEN_B));
    check("st_b_data", 32'(last_dout[7:0]), 32'hA5);
    check("st_b_addr", last_addr, 32'hA000_0001);
    xfer(0, 0, `MEM_LEN_H, 0, 32'h101, 0, 1);
    xfer(0, 0, `MEM_LEN_W, 0, 32'h102, 0, 1);
    low_cnt = 5;
    xfer(0, 0, `MEM_LEN_W, 0, 32'h100, 0, 8);
    check("stall_rd", rsp_rdata, 32'h8001_7FFE);

    rand_rdy = 1;
    for (int i = 0; i < 40; i++)
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
           1'($urandom_range(0, 1)), 32'h300 + 32'($urandom_range(0, 63)), $urandom, 0);
    rand_rdy = 0;

    @(negedge clk) t_valid = 1;
    @(posedge clk);
    #1 t_valid = 0;
    c = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (t_rsp_valid) begin c = i; break; end
    end
    check("to_latency", c, 5);
    check("to_err", 32'(t_err), 32'h2);
    check("to_rdata", t_rdata, 0);
    check("to_ready", 32'(t_ready), 1);

    low_cnt = 100;
    @(negedge clk);
    req_valid = 1; req_write = 0; req_exec = 0; req_len = `MEM_LEN_W; req_addr = 32'h100;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (2) @(negedge clk);
    check("abort_in_access", 32'(db_accessType), 32'(`MEM_ACCESS_R));
    res = 1;
    @(posedge clk);
    #1 res = 0;
    low_cnt = 0;
    @(negedge clk);
    check("abort_type", 32'(db_accessType), 32'(`MEM_ACCESS_NONE));
    check("abort_valid", 32'(rsp_valid), 0);
    check("abort_ready", 32'(req_ready), 1);
    seen = 0;
    repeat (10) @(negedge clk) seen |= rsp_valid;
    check("abort_no_rsp", 32'(seen), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
